// File: rtl/aib_axi_link_bringup_ctrl.sv
// rtl/aib_axi_link_bringup_ctrl.sv - AIB-to-AXI bridge link bring-up sequencer
//
// Purpose: streams a config table over AVMM, releases the near-side adapter
// reset, raises near-side MAC ready, then waits for far-side MAC ready and
// RX alignment. Opens the AXI bridge only while the link is up; retries
// with a reset backoff on timeout or link drop, giving up after MAX_RETRY.
//
// Ports:
//   clk_wr, rst_wr          clock, synchronous active-high reset
//   start                   level request: 1 = bring up / keep up, 0 = shut down
//   cfg_table               NUM_CFG entries of {addr[16:0], wdata[31:0]}
//   avmm_*                  AVMM config write master (byte_en tied 4'hF)
//   ns_adapter_rstn         near-side adapter reset, active low
//   ns_mac_rdy              near-side MAC ready
//   fs_mac_rdy              far-side MAC ready (async, synchronised here)
//   rx_align_done           RX alignment done (async, synchronised here)
//   axi_en                  AXI traffic enable, high only in LINK_UP
//   link_fail               high only in FAIL
//   state                   current FSM state
//   retry_cnt               consecutive BACKOFF entries since the last LINK_UP
//   linkup_cnt, drop_cnt    saturating statistics (AIB_BRINGUP_STATS_EN only)
//
// Optional feature macro: AIB_BRINGUP_STATS_EN

module aib_axi_link_bringup_ctrl #(
  parameter int NUM_CFG     = 4,
  parameter int RSTN_DLY    = 16,
  parameter int TIMEOUT     = 1024,
  parameter int BACKOFF_CYC = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic                                         clk_wr,
  input  logic                                         rst_wr,
  input  logic                                         start,
  input  logic [((NUM_CFG > 0) ? NUM_CFG : 1)*49-1:0] cfg_table,
  output logic [16:0]                                  avmm_addr,
  output logic [3:0]                                   avmm_byte_en,
  output logic                                         avmm_write,
  output logic [31:0]                                  avmm_wdata,
  input  logic                                         avmm_waitreq,
  output logic                                         ns_adapter_rstn,
  output logic                                         ns_mac_rdy,
  input  logic                                         fs_mac_rdy,
  input  logic                                         rx_align_done,
  output logic                                         axi_en,
  output logic                                         link_fail,
  output logic [2:0]                                   state,
  output logic [3:0]                                   retry_cnt
`ifdef AIB_BRINGUP_STATS_EN
  ,
  output logic [15:0]                                  linkup_cnt,
  output logic [15:0]                                  drop_cnt
`endif
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CFG        = 3'd1;
  localparam logic [2:0] S_RST_REL    = 3'd2;
  localparam logic [2:0] S_MAC_RDY    = 3'd3;
  localparam logic [2:0] S_WAIT_ALIGN = 3'd4;
  localparam logic [2:0] S_LINK_UP    = 3'd5;
  localparam logic [2:0] S_BACKOFF    = 3'd6;
  localparam logic [2:0] S_FAIL       = 3'd7;

  localparam int TMAX = (RSTN_DLY > TIMEOUT)
                        ? ((RSTN_DLY > BACKOFF_CYC) ? RSTN_DLY : BACKOFF_CYC)
                        : ((TIMEOUT > BACKOFF_CYC) ? TIMEOUT : BACKOFF_CYC);
  localparam int TW       = $clog2(TMAX + 1);
  localparam int IDX_W    = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int LAST_IDX = (NUM_CFG > 0) ? NUM_CFG - 1 : 0;

  logic [2:0]       state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [TW-1:0]    timer, timer_ld;
  logic [48:0]      entry_n;
  logic             fs_s1, fs_sync, al_s1, align_sync;
  logic             timer_done;

  assign avmm_byte_en = 4'hF;
  assign timer_done   = (timer == '0);
  assign entry_n      = cfg_table[49*int'(idx_n) +: 49];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_n   = '0;
          state_n = (NUM_CFG == 0) ? S_RST_REL : S_CFG;
        end
      end
      S_CFG: begin
        // start is deliberately ignored: a half-written table is never left behind
        if (avmm_write && !avmm_waitreq) begin
          if (idx == IDX_W'(LAST_IDX)) state_n = S_RST_REL;
          else                         idx_n   = idx + 1'b1;
        end
      end
      S_RST_REL:    if (timer_done) state_n = S_MAC_RDY;
      S_MAC_RDY: begin
        if (fs_sync)         state_n = S_WAIT_ALIGN;
        else if (timer_done) state_n = S_BACKOFF;
      end
      S_WAIT_ALIGN: begin
        if (align_sync)                  state_n = S_LINK_UP;
        else if (timer_done || !fs_sync) state_n = S_BACKOFF;
      end
      S_LINK_UP:    if (!fs_sync || !align_sync) state_n = S_BACKOFF;
      S_BACKOFF: begin
        // retry_cnt already holds the count including this entry
        if (retry_cnt >= 4'(MAX_RETRY)) state_n = S_FAIL;
        else if (timer_done)            state_n = S_RST_REL;
      end
      S_FAIL:       if (!start) state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
    // Shutdown request overrides every other transition outside IDLE/CFG/FAIL
    if (!start && (state >= S_RST_REL) && (state <= S_BACKOFF)) state_n = S_IDLE;
  end

  // Dwell time minus one, loaded whenever a state is entered
  always_comb begin
    case (state_n)
      S_RST_REL:                timer_ld = TW'(RSTN_DLY - 1);
      S_MAC_RDY, S_WAIT_ALIGN:  timer_ld = TW'(TIMEOUT - 1);
      S_BACKOFF:                timer_ld = TW'(BACKOFF_CYC - 1);
      default:                  timer_ld = '0;
    endcase
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state           <= S_IDLE;
      idx             <= '0;
      timer           <= '0;
      fs_s1           <= 1'b0;
      fs_sync         <= 1'b0;
      al_s1           <= 1'b0;
      align_sync      <= 1'b0;
      avmm_write      <= 1'b0;
      avmm_addr       <= '0;
      avmm_wdata      <= '0;
      ns_adapter_rstn <= 1'b0;
      ns_mac_rdy      <= 1'b0;
      axi_en          <= 1'b0;
      link_fail       <= 1'b0;
      retry_cnt       <= '0;
    end else begin
      fs_s1      <= fs_mac_rdy;
      fs_sync    <= fs_s1;
      al_s1      <= rx_align_done;
      align_sync <= al_s1;

      state <= state_n;
      idx   <= idx_n;
      if (state_n != state)  timer <= timer_ld;
      else if (!timer_done)  timer <= timer - TW'(1);

      // Outputs are registered from the next state so they line up with state
      avmm_write      <= (state_n == S_CFG);
      avmm_addr       <= (state_n == S_CFG) ? entry_n[48:32] : 17'd0;
      avmm_wdata      <= (state_n == S_CFG) ? entry_n[31:0]  : 32'd0;
      ns_adapter_rstn <= (state_n >= S_RST_REL) && (state_n <= S_LINK_UP);
      ns_mac_rdy      <= (state_n >= S_MAC_RDY) && (state_n <= S_LINK_UP);
      axi_en          <= (state_n == S_LINK_UP);
      link_fail       <= (state_n == S_FAIL);

      if (state_n == S_IDLE || state_n == S_LINK_UP)
        retry_cnt <= '0;
      else if (state_n == S_BACKOFF && state != S_BACKOFF)
        retry_cnt <= retry_cnt + 4'd1;
    end
  end

`ifdef AIB_BRINGUP_STATS_EN
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      linkup_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (state_n == S_LINK_UP && state != S_LINK_UP && linkup_cnt != 16'hFFFF)
        linkup_cnt <= linkup_cnt + 16'd1;
      if (state == S_LINK_UP && state_n == S_BACKOFF && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aib_axi_link_bringup_ctrl.sv
// tb/tb_aib_axi_link_bringup_ctrl.sv - bench for aib_axi_link_bringup_ctrl
module tb_aib_axi_link_bringup_ctrl;
  localparam int NUM_CFG     = 4;
  localparam int RSTN_DLY    = 16;
  localparam int TIMEOUT     = 1024;
  localparam int BACKOFF_CYC = 64;
  localparam int MAX_RETRY   = 3;

  localparam int P_IDLE = 0, P_CFG = 1, P_RST = 2, P_MAC = 3;
  localparam int P_WA = 4, P_LU = 5, P_BO = 6, P_FAIL = 7;

  logic                 clk_wr = 1'b0;
  logic                 rst_wr, start, avmm_waitreq, fs_mac_rdy, rx_align_done;
  logic [NUM_CFG*49-1:0] cfg_table;
  logic [16:0]          avmm_addr;
  logic [3:0]           avmm_byte_en;
  logic                 avmm_write;
  logic [31:0]          avmm_wdata;
  logic                 ns_adapter_rstn, ns_mac_rdy, axi_en, link_fail;
  logic [2:0]           state;
  logic [3:0]           retry_cnt;
`ifdef AIB_BRINGUP_STATS_EN
  logic [15:0]          linkup_cnt, drop_cnt;
`endif

  always #5 clk_wr = ~clk_wr;

  aib_axi_link_bringup_ctrl #(
    .NUM_CFG(NUM_CFG), .RSTN_DLY(RSTN_DLY), .TIMEOUT(TIMEOUT),
    .BACKOFF_CYC(BACKOFF_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .start(start), .cfg_table(cfg_table),
    .avmm_addr(avmm_addr), .avmm_byte_en(avmm_byte_en), .avmm_write(avmm_write),
    .avmm_wdata(avmm_wdata), .avmm_waitreq(avmm_waitreq),
    .ns_adapter_rstn(ns_adapter_rstn), .ns_mac_rdy(ns_mac_rdy),
    .fs_mac_rdy(fs_mac_rdy), .rx_align_done(rx_align_done),
    .axi_en(axi_en), .link_fail(link_fail), .state(state), .retry_cnt(retry_cnt)
`ifdef AIB_BRINGUP_STATS_EN
    , .linkup_cnt(linkup_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic [48:0] tab [NUM_CFG];
  logic [48:0] beats [$];
  int hold2 = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_wr);
      #2;
    end
  endtask

  // Reference model: phase + cycles spent in it, beats delivered, retries
  int m_ph = P_IDLE, m_age = 0, m_beat = 0, m_retry = 0, m_lu = 0, m_dr = 0;
  logic [1:0] m_fs = 2'b00, m_al = 2'b00;

  always @(posedge clk_wr) begin
    int nph;
    logic fs_s, al_s;
    if (rst_wr) begin
      m_ph = P_IDLE; m_age = 0; m_beat = 0; m_retry = 0; m_lu = 0; m_dr = 0;
      m_fs = 2'b00; m_al = 2'b00;
    end else begin
      fs_s = m_fs[1];
      al_s = m_al[1];
      nph  = m_ph;
      if (m_ph == P_IDLE) begin
        if (start) begin m_beat = 0; nph = (NUM_CFG == 0) ? P_RST : P_CFG; end
      end else if (m_ph == P_CFG) begin
        if (!avmm_waitreq) begin
          m_beat++;
          if (m_beat == NUM_CFG) nph = P_RST;
        end
      end else if (m_ph == P_RST) begin
        if (m_age + 1 >= RSTN_DLY) nph = P_MAC;
      end else if (m_ph == P_MAC) begin
        if (fs_s) nph = P_WA;
        else if (m_age + 1 >= TIMEOUT) nph = P_BO;
      end else if (m_ph == P_WA) begin
        if (al_s) nph = P_LU;
        else if (!fs_s || m_age + 1 >= TIMEOUT) nph = P_BO;
      end else if (m_ph == P_LU) begin
        if (!fs_s || !al_s) nph = P_BO;
      end else if (m_ph == P_BO) begin
        if (m_retry >= MAX_RETRY) nph = P_FAIL;
        else if (m_age + 1 >= BACKOFF_CYC) nph = P_RST;
      end else begin
        if (!start) nph = P_IDLE;
      end
      if (!start && m_ph >= P_RST && m_ph <= P_BO) nph = P_IDLE;
      if (nph == P_BO && m_ph != P_BO) m_retry++;
      if (nph == P_IDLE || nph == P_LU) m_retry = 0;
      if (nph == P_LU && m_ph != P_LU && m_lu < 65535) m_lu++;
      if (nph == P_BO && m_ph == P_LU && m_dr < 65535) m_dr++;
      m_age = (nph != m_ph) ? 0 : m_age + 1;
      m_ph  = nph;
      m_fs  = {m_fs[0], fs_mac_rdy};
      m_al  = {m_al[0], rx_align_done};
    end
  end

  always @(negedge clk_wr) begin
    logic e_w;
    logic [48:0] e_ent, a_ent;
    if (chk_en) begin
      e_w   = (m_ph == P_CFG) && (m_beat < NUM_CFG);
      e_ent = e_w ? tab[m_beat] : 49'd0;
      a_ent = avmm_write ? {avmm_addr, avmm_wdata} : 49'd0;
      chk("cycle_outputs",
          {state, avmm_write, ns_adapter_rstn, ns_mac_rdy, axi_en, link_fail,
           retry_cnt, avmm_byte_en, a_ent},
          {3'(m_ph), e_w, (m_ph >= P_RST && m_ph <= P_LU), (m_ph >= P_MAC && m_ph <= P_LU),
           (m_ph == P_LU), (m_ph == P_FAIL), 4'(m_retry), 4'hF, e_ent});
`ifdef AIB_BRINGUP_STATS_EN
      chk("cycle_stats", {linkup_cnt, drop_cnt}, {16'(m_lu), 16'(m_dr)});
`endif
    end
    if (!rst_wr && avmm_write && !avmm_waitreq) beats.push_back({avmm_addr, avmm_wdata});
    if (avmm_write && avmm_addr == tab[2][48:32]) hold2++;
  end

  initial begin
    int cnt;
    rst_wr = 1'b1; start = 1'b0; avmm_waitreq = 1'b0;
    fs_mac_rdy = 1'b0; rx_align_done = 1'b0;
    for (int i = 0; i < NUM_CFG; i++) begin
      tab[i] = {17'h00100 + 17'(4 * i), 32'hA5A5_0000 + 32'(i) * 32'h0101_0101};
      cfg_table[49*i +: 49] = tab[i];
    end
    cyc(3);
    chk("reset_state", state, 0);
    chk("reset_ctl", {avmm_write, ns_adapter_rstn, ns_mac_rdy, axi_en, link_fail}, 0);
    chk("reset_avmm", {avmm_addr, avmm_wdata}, 0);
    chk("reset_retry", retry_cnt, 0);
    chk("byte_en", avmm_byte_en, 4'hF);
    rst_wr = 1'b0;
    chk_en = 1'b1;
    cyc(2);

    // Config stream with no stalls, then reset release and MAC ready
    beats.delete();
    start = 1'b1;
    cnt = 0;
    while (!ns_adapter_rstn && cnt < 50) begin cyc(1); cnt++; end
    chk("t1_rstn_rise", cnt, 5);
    chk("t1_beat_count", beats.size(), 4);
    for (int i = 0; i < beats.size() && i < NUM_CFG; i++) chk("t1_beat", beats[i], tab[i]);
    cnt = 0;
    while (!ns_mac_rdy && cnt < 50) begin cyc(1); cnt++; end
    chk("t1_mac_rdy_delay", cnt, 16);
    chk("t1_state", state, 3);

    // Far side never answers: three timeouts then FAIL
    for (int r = 1; r <= MAX_RETRY; r++) begin
      cnt = 0;
      while (ns_adapter_rstn && cnt < 2000) begin cyc(1); cnt++; end
      chk("t4_timeout", cnt, 1024);
      chk("t4_retry", retry_cnt, r);
      chk("t4_backoff_state", state, 6);
      if (r < MAX_RETRY) begin
        cnt = 0;
        while (!ns_adapter_rstn && cnt < 200) begin cyc(1); cnt++; end
        chk("t4_backoff_len", cnt, 64);
        cnt = 0;
        while (!ns_mac_rdy && cnt < 50) begin cyc(1); cnt++; end
        chk("t4_mac_rdy_delay", cnt, 16);
      end
    end
    cyc(1);
    chk("t4_fail", {state, link_fail, ns_adapter_rstn}, {3'd7, 1'b1, 1'b0});
    start = 1'b0;
    cyc(1);
    chk("t4_idle", {state, link_fail, retry_cnt}, {3'd0, 1'b0, 4'd0});

    // Stall beat 2 for five cycles
    beats.delete();
    hold2 = 0;
    start = 1'b1;
    cyc(3);
    avmm_waitreq = 1'b1;
    cyc(5);
    avmm_waitreq = 1'b0;
    cnt = 0;
    while (!ns_adapter_rstn && cnt < 50) begin cyc(1); cnt++; end
    chk("t2_beat_count", beats.size(), 4);
    for (int i = 0; i < beats.size() && i < NUM_CFG; i++) chk("t2_beat", beats[i], tab[i]);
    chk("t2_beat2_hold", hold2, 6);
    cnt = 0;
    while (!ns_mac_rdy && cnt < 50) begin cyc(1); cnt++; end
    chk("t2_mac_rdy_delay", cnt, 16);

    // Link up
    fs_mac_rdy = 1'b1;
    cyc(10);
    rx_align_done = 1'b1;
    cnt = 0;
    while (!axi_en && cnt < 50) begin cyc(1); cnt++; end
    chk("t3_axi_en_latency", cnt, 3);
    chk("t3_linkup", {state, retry_cnt}, {3'd5, 4'd0});

    // One-cycle alignment drop, backoff, relink
    rx_align_done = 1'b0;
    cyc(1);
    rx_align_done = 1'b1;
    cnt = 1;
    while (axi_en && cnt < 50) begin cyc(1); cnt++; end
    chk("t5_drop_latency", cnt, 3);
    chk("t5_backoff", {state, retry_cnt, ns_adapter_rstn}, {3'd6, 4'd1, 1'b0});
    cnt = 0;
    while (!axi_en && cnt < 300) begin cyc(1); cnt++; end
    chk("t5_relink_time", cnt, 82);
    chk("t5_relink_retry", retry_cnt, 0);
`ifdef AIB_BRINGUP_STATS_EN
    chk("t5_stats", {linkup_cnt, drop_cnt}, {16'd2, 16'd1});
`endif

    // Reset during a stalled config write
    start = 1'b0;
    cyc(2);
    avmm_waitreq = 1'b1;
    start = 1'b1;
    cyc(2);
    chk("t6_stalled_cfg", {state, avmm_write}, {3'd1, 1'b1});
    rst_wr = 1'b1;
    cyc(1);
    chk("t6_reset_ctl", {state, avmm_write, ns_adapter_rstn, ns_mac_rdy, axi_en, link_fail},
        {3'd0, 5'd0});
    chk("t6_reset_avmm", {avmm_addr, avmm_wdata, retry_cnt}, 0);
    rst_wr = 1'b0;
    start = 1'b0;
    avmm_waitreq = 1'b0;
    fs_mac_rdy = 1'b0;
    rx_align_done = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
